// File: rtl/hwag_coil_sched.sv
// hwag_coil_sched: multi-channel ignition coil scheduler fed by the HWAG angle
// counter. Each channel owns a set/reset angle pair; a single window comparator
// is shared round-robin across the channels. Configuration writes land in shadow
// registers and move to the active pair only at an angle wrap, or at any time
// while the scheduler is disabled.
// Optional build macro: HWAG_COIL_DWELL_LIMIT_EN adds a per-channel dwell-time
// limit (DWELL_MAX clocks) with a lockout and a dwell_fault pulse output.
module hwag_coil_sched #(
  parameter int CH          = 4,
  parameter int ANGLE_WIDTH = 24,
  parameter int MAXACR      = 3839
`ifdef HWAG_COIL_DWELL_LIMIT_EN
  ,
  parameter int unsigned DWELL_MAX = 32'd2000000
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [ANGLE_WIDTH-1:0] angle,
  input  logic                   cfg_we,
  input  logic [$clog2(CH):0]    cfg_addr,
  input  logic [ANGLE_WIDTH-1:0] cfg_data,
  output logic                   cfg_ack,
  output logic                   cfg_err,
`ifdef HWAG_COIL_DWELL_LIMIT_EN
  output logic [CH-1:0]          dwell_fault,
`endif
  output logic [CH-1:0]          coil
);

  localparam int PW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [ANGLE_WIDTH-1:0] L_MAXACR   = ANGLE_WIDTH'(MAXACR);
  localparam logic [PW-1:0]          L_PTR_LAST = PW'(CH - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mode_e;

  mode_e                  w_mode;
  logic                   w_wrap;
  logic                   w_wr_ok;
  logic                   w_win;
  logic [31:0]            w_wr_ch;
  logic [PW-1:0]          w_ptr_next;
  logic [ANGLE_WIDTH-1:0] w_sel_set;
  logic [ANGLE_WIDTH-1:0] w_sel_rst;

  logic [ANGLE_WIDTH-1:0] r_act_set [CH];
  logic [ANGLE_WIDTH-1:0] r_act_rst [CH];
  logic [ANGLE_WIDTH-1:0] r_sh_set  [CH];
  logic [ANGLE_WIDTH-1:0] r_sh_rst  [CH];
  logic [CH-1:0]          r_pend;
  logic [CH-1:0]          r_coil;
  logic [PW-1:0]          r_ptr;
  logic [ANGLE_WIDTH-1:0] r_angle_prev;
  logic                   r_ack;
  logic                   r_err;

`ifdef HWAG_COIL_DWELL_LIMIT_EN
  logic [31:0]            r_cnt [CH];
  logic [CH-1:0]          r_lock;
  logic [CH-1:0]          r_fault;
`endif

  // Mode decode, wrap detect, write qualification and scan pointer advance.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_mode = IDLE;
    if (ena) w_mode = RUN;
    w_wrap     = (angle < r_angle_prev);
    w_wr_ch    = 32'(cfg_addr) >> 1;
    w_wr_ok    = cfg_we && (cfg_data <= L_MAXACR) && (w_wr_ch < 32'(CH));
    w_ptr_next = (r_ptr == L_PTR_LAST) ? '0 : r_ptr + 1'b1;
  end

  // Shared comparator: select the scanned channel's active pair and test the window.
  always_comb begin
    w_sel_set = '0;
    w_sel_rst = '0;
    for (int i = 0; i < CH; i++) begin
      if (r_ptr == PW'(i)) begin
        w_sel_set = r_act_set[i];
        w_sel_rst = r_act_rst[i];
      end
    end
    w_win = 1'b0;
    if (w_sel_set < w_sel_rst)
      w_win = (angle >= w_sel_set) && (angle < w_sel_rst);
    else if (w_sel_set > w_sel_rst)
      w_win = (angle >= w_sel_set) || (angle < w_sel_rst);
  end

  // Previous angle for wrap detection and one-clock write handshake pulses.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      r_angle_prev <= '0;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_angle_prev <= angle;
      r_ack        <= w_wr_ok;
      r_err        <= cfg_we && !w_wr_ok;
    end
  end

  // Shadow/active configuration: promote pending shadows at wrap or while idle,
  // then let a same-cycle write land in the shadow and re-arm pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the register arrays are reset on purpose: zero set == zero reset means "channel disabled".
      for (int i = 0; i < CH; i++) begin
        r_act_set[i] <= '0;
        r_act_rst[i] <= '0;
        r_sh_set[i]  <= '0;
        r_sh_rst[i]  <= '0;
      end
      r_pend <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if ((w_mode == IDLE || w_wrap) && r_pend[i]) begin
          r_act_set[i] <= r_sh_set[i];
          r_act_rst[i] <= r_sh_rst[i];
          r_pend[i]    <= 1'b0;
        end
        if (w_wr_ok && (w_wr_ch == 32'(i))) begin
          if (cfg_addr[0]) r_sh_rst[i] <= cfg_data;
          else             r_sh_set[i] <= cfg_data;
          r_pend[i] <= 1'b1;
        end
      end
    end
  end

  // Round-robin scan: register the comparator result into the scanned coil bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr  <= '0;
      r_coil <= '0;
`ifdef HWAG_COIL_DWELL_LIMIT_EN
      for (int i = 0; i < CH; i++) r_cnt[i] <= '0;
      r_lock  <= '0;
      r_fault <= '0;
`endif
    end else if (w_mode == IDLE) begin
      r_ptr  <= '0;
      r_coil <= '0;
`ifdef HWAG_COIL_DWELL_LIMIT_EN
      for (int i = 0; i < CH; i++) r_cnt[i] <= '0;
      r_lock  <= '0;
      r_fault <= '0;
`endif
    end else begin
      r_ptr <= w_ptr_next;
      for (int i = 0; i < CH; i++) begin
        if (r_ptr == PW'(i)) begin
`ifdef HWAG_COIL_DWELL_LIMIT_EN
          r_coil[i] <= w_win && !r_lock[i];
          if (!w_win) r_lock[i] <= 1'b0;
`else
          r_coil[i] <= w_win;
`endif
        end
`ifdef HWAG_COIL_DWELL_LIMIT_EN
        // A trip overrides the scan result for this edge and arms the lockout.
        r_fault[i] <= 1'b0;
        if (r_coil[i]) begin
          if (r_cnt[i] == DWELL_MAX - 1) begin
            r_coil[i]  <= 1'b0;
            r_lock[i]  <= 1'b1;
            r_fault[i] <= 1'b1;
            r_cnt[i]   <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
`endif
      end
    end
  end

  assign coil    = r_coil;
  assign cfg_ack = r_ack;
  assign cfg_err = r_err;
`ifdef HWAG_COIL_DWELL_LIMIT_EN
  assign dwell_fault = r_fault;
`endif

endmodule

// File: tb/tb_hwag_coil_sched.sv
// Self-checking bench for hwag_coil_sched (default build, CH=4, MAXACR=3839).
// A behavioural model tracks active/shadow pairs and the scan slot; directed
// revolutions check the window placement, and a random phase cross-checks the model.
module tb_hwag_coil_sched;

  localparam int CH  = 4;
  localparam int AW  = 24;
  localparam int MAX = 3839;

  logic          clk;
  logic          rst;
  logic          ena;
  logic [AW-1:0] angle;
  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [AW-1:0] cfg_data;
  logic          cfg_ack;
  logic          cfg_err;
  logic [CH-1:0] coil;

  hwag_coil_sched #(.CH(CH), .ANGLE_WIDTH(AW), .MAXACR(MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .angle    (angle),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_ack  (cfg_ack),
    .cfg_err  (cfg_err),
    .coil     (coil)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, expressed in plain integers.
  int            m_as [CH];
  int            m_ar [CH];
  int            m_ss [CH];
  int            m_sr [CH];
  bit            m_pend [CH];
  int            m_slot;
  logic [CH-1:0] m_coil;
  bit            m_ack;
  bit            m_err;
  int            m_prev;

  logic [CH-1:0] cap [3840];

  function automatic bit win(input int s, input int r, input int a);
    if (s < r) return (a >= s) && (a < r);
    if (s > r) return (a >= s) || (a < r);
    return 1'b0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < CH; i++) begin
      m_as[i] = 0; m_ar[i] = 0; m_ss[i] = 0; m_sr[i] = 0; m_pend[i] = 0;
    end
    m_slot = 0; m_coil = '0; m_ack = 0; m_err = 0; m_prev = 0;
  endtask

  // One clock edge of the specified behaviour, given the inputs sampled at it.
  task automatic m_edge(input bit e, input int a, input bit we, input logic [2:0] ad, input int d);
    int ch;
    bit wrap;
    bit ok;
    ch   = int'(ad >> 1);
    wrap = (a < m_prev);
    if (e) begin
      m_coil[m_slot] = win(m_as[m_slot], m_ar[m_slot], a);
      m_slot = (m_slot + 1) % CH;
    end else begin
      m_coil = '0;
      m_slot = 0;
    end
    for (int i = 0; i < CH; i++) begin
      if ((!e || wrap) && m_pend[i]) begin
        m_as[i] = m_ss[i]; m_ar[i] = m_sr[i]; m_pend[i] = 0;
      end
    end
    ok = we && (d <= MAX) && (ch < CH);
    if (ok) begin
      if (ad[0]) m_sr[ch] = d; else m_ss[ch] = d;
      m_pend[ch] = 1;
    end
    m_ack  = ok;
    m_err  = we && !ok;
    m_prev = a;
  endtask

  // Drive one cycle, advance model and DUT, compare all outputs.
  task automatic tick(input bit e, input int a, input bit we, input logic [2:0] ad, input int d);
    ena = e; angle = AW'(a); cfg_we = we; cfg_addr = ad; cfg_data = AW'(d);
    @(posedge clk);
    m_edge(e, a, we, ad, d);
    #1;
    check("cycle", {26'd0, coil, cfg_ack, cfg_err}, {26'd0, m_coil, m_ack, m_err});
  endtask

  // One revolution 0..MAX, optionally with a write at angle wa; captures coil per angle.
  task automatic sweep(input bit wr, input int wa, input logic [2:0] wad, input int wd);
    for (int a = 0; a <= MAX; a++) begin
      if (wr && a == wa) tick(1, a, 1, wad, wd);
      else               tick(1, a, 0, 3'd0, 0);
      cap[a] = coil;
    end
  endtask

  task automatic chk_rng(input string name, input int b, input int lo, input int hi, input bit v);
    int bad;
    bad = 0;
    for (int a = lo; a <= hi; a++) if (cap[a][b] !== v) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic       we;
    logic [2:0] addr;
    int         data;
    logic       exp_ack;
    logic       exp_err;
  } vec_t;

  vec_t vt [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise;
    int fall;
    int nz;
    int ra;
    vec_t v;

    vt[0] = '{1'b1, 3'd0, 32,       1'b1, 1'b0};
    vt[1] = '{1'b1, 3'd1, 96,       1'b1, 1'b0};
    vt[2] = '{1'b1, 3'd2, 3800,     1'b1, 1'b0};
    vt[3] = '{1'b1, 3'd3, 40,       1'b1, 1'b0};
    vt[4] = '{1'b1, 3'd4, 3840,     1'b0, 1'b1};
    vt[5] = '{1'b1, 3'd5, 3839,     1'b1, 1'b0};
    vt[6] = '{1'b0, 3'd6, 100,      1'b0, 1'b0};
    vt[7] = '{1'b1, 3'd7, 24'hFFFFFF, 1'b0, 1'b1};

    rst = 1'b1; ena = 1'b0; angle = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    m_reset();
    #3 rst = 1'b0;
    #1;
    check("reset_coil", 32'(coil), 32'd0);
    check("reset_ack", 32'(cfg_ack), 32'd0);
    check("reset_err", 32'(cfg_err), 32'd0);
    #22 rst = 1'b1;

    // All channels disabled after reset: a full sweep keeps every coil off.
    sweep(0, 0, 3'd0, 0);
    nz = 0;
    for (int a = 0; a <= MAX; a++) if (cap[a] != '0) nz++;
    check("disabled_sweep", 32'(nz), 32'd0);

    // Configuration writes at a constant angle (no wrap), table driven.
    for (int k = 0; k < 8; k++) begin
      v = vt[k];
      tick(1, MAX, v.we, v.addr, v.data);
      check($sformatf("wr%0d_ack", k), 32'(cfg_ack), 32'(v.exp_ack));
      check($sformatf("wr%0d_err", k), 32'(cfg_err), 32'(v.exp_err));
    end
    tick(1, MAX, 0, 3'd0, 0);
    check("ack_one_clock", 32'({cfg_ack, cfg_err}), 32'd0);

    // Rev A: new windows take effect after the wrap into this sweep.
    sweep(0, 0, 3'd0, 0);
    rise = -1; fall = -1;
    for (int a = 0; a <= MAX; a++) begin
      if (rise < 0 && cap[a][0]) rise = a;
      else if (rise >= 0 && fall < 0 && !cap[a][0]) fall = a;
    end
    check("A_ch0_rise_32_35", 32'(rise >= 32 && rise <= 35), 32'd1);
    check("A_ch0_fall_96_99", 32'(fall >= 96 && fall <= 99), 32'd1);
    chk_rng("A_ch0_off", 0, 99, MAX, 1'b0);
    chk_rng("A_ch1_off", 1, 43, 3799, 1'b0);
    chk_rng("A_ch1_on", 1, 3803, MAX, 1'b1);

    // Rev B: mid-revolution write of ch0 set=500 must not disturb this revolution.
    sweep(1, 200, 3'd0, 500);
    chk_rng("B_ch0_on", 0, 36, 95, 1'b1);
    chk_rng("B_ch0_off", 0, 99, MAX, 1'b0);
    chk_rng("B_ch1_on", 1, 3, 39, 1'b1);
    chk_rng("B_ch1_off", 1, 43, 3799, 1'b0);

    // Rev C: wrapped window 500..96.
    sweep(0, 0, 3'd0, 0);
    chk_rng("C_ch0_on_lo", 0, 4, 95, 1'b1);
    chk_rng("C_ch0_off", 0, 99, 499, 1'b0);
    chk_rng("C_ch0_on_hi", 0, 503, MAX, 1'b1);

    // Rev D writes set=1000; rev E writes set=2000 in the wrap cycle itself.
    sweep(1, 100, 3'd0, 1000);
    chk_rng("D_ch0_hold", 0, 503, MAX, 1'b1);
    sweep(1, 0, 3'd0, 2000);
    chk_rng("E_ch0_off", 0, 99, 999, 1'b0);
    chk_rng("E_ch0_on", 0, 1003, MAX, 1'b1);
    sweep(0, 0, 3'd0, 0);
    chk_rng("F_ch0_off", 0, 99, 1999, 1'b0);
    chk_rng("F_ch0_on", 0, 2003, MAX, 1'b1);

    // Dropping ena clears the coils on the next edge.
    check("pre_drop_coil0", 32'(coil[0]), 32'd1);
    tick(0, MAX, 0, 3'd0, 0);
    check("ena_drop", 32'(coil), 32'd0);

    // Asynchronous reset in the middle of a dwell.
    for (int k = 0; k < CH; k++) tick(1, MAX, 0, 3'd0, 0);
    check("dwell_on", 32'(coil[0]), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_coil", 32'(coil), 32'd0);
    m_reset();
    #10 rst = 1'b1;
    for (int k = 0; k < 8; k++) tick(1, 2100 + k, 0, 3'd0, 0);
    check("post_rst_disabled", 32'(coil), 32'd0);

    // Random phase: drifting angle with wraps, random writes and enable glitches.
    ra = 0;
    for (int k = 0; k < 3000; k++) begin
      bit e;
      bit we;
      int d;
      ra = ra + int'($urandom_range(0, 9));
      if (ra > MAX) ra = ra - (MAX + 1);
      if ($urandom_range(0, 199) == 0) ra = int'($urandom_range(0, MAX));
      e  = ($urandom_range(0, 59) != 0);
      we = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 7))
        0:       d = MAX + 1;
        1:       d = int'($urandom_range(0, 24'hFFFFFF));
        2:       d = MAX;
        default: d = int'($urandom_range(0, MAX));
      endcase
      tick(e, ra, we, 3'($urandom_range(0, 7)), d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
